// File: rtl/palette_lookup_arbiter.sv
// palette_lookup_arbiter: shared writable RGB palette with round-robin lookup arbitration.
// Several sprite pipelines present colour indices. One lookup is granted per cycle,
// and its result is returned one cycle later.
// Optional feature macro: PALETTE_DOUBLE_BUFFER_EN. When it is defined, the palette
// has two banks. Writes go to the inactive bank, and i_frame_sync swaps the banks.
module palette_lookup_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [NUM_REQ-1:0]         i_req_valid,
    input  logic [NUM_REQ*IDX_W-1:0]   i_req_index,
    output logic [NUM_REQ-1:0]         o_req_ready,
    output logic                       o_rsp_valid,
    output logic [$clog2(NUM_REQ)-1:0] o_rsp_id,
    output logic [11:0]                o_rsp_rgb,
    output logic                       o_rsp_transparent,
    input  logic                       i_cfg_we,
    input  logic [IDX_W-1:0]           i_cfg_addr,
    input  logic [11:0]                i_cfg_data,
    input  logic                       i_frame_sync
);

    localparam int unsigned ID_W  = $clog2(NUM_REQ);
    localparam int unsigned DEPTH = 2 ** IDX_W;
    localparam int unsigned RGB_W = 12;

    logic [ID_W-1:0]  r_rr_ptr;
    logic             r_rsp_valid;
    logic [ID_W-1:0]  r_rsp_id;
    logic [RGB_W-1:0] r_rsp_rgb;
    logic             r_rsp_transparent;

    logic             w_grant_found;
    logic [ID_W-1:0]  w_grant_id;
    logic [IDX_W-1:0] w_sel_index;
    logic [RGB_W-1:0] w_lookup_rgb;
    logic             w_cfg_block;

`ifdef PALETTE_DOUBLE_BUFFER_EN
    logic             r_bank;
    logic [RGB_W-1:0] r_palette [2][DEPTH];

    // Writes go to the shadow bank, so they never stall the sprite pipelines.
    assign w_cfg_block  = 1'b0;
    assign w_lookup_rgb = r_palette[r_bank][w_sel_index];

    // Bank select flips at each vblank pulse.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_bank <= 1'b0;
        end else if (i_frame_sync) begin
            r_bank <= ~r_bank;
        end
    end

    // Palette storage. The target is the bank that is inactive before this edge.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int unsigned b = 0; b < 2; b++) begin
                for (int unsigned e = 0; e < DEPTH; e++) begin
                    r_palette[b][e] <= '0;
                end
            end
        end else if (i_cfg_we) begin
            r_palette[~r_bank][i_cfg_addr] <= i_cfg_data;
        end
    end
`else
    logic             w_unused_frame_sync;
    logic [RGB_W-1:0] r_palette [DEPTH];

    // A config write owns the cycle, so a read and a write never meet at the same edge.
    assign w_cfg_block         = i_cfg_we;
    assign w_lookup_rgb        = r_palette[w_sel_index];
    assign w_unused_frame_sync = i_frame_sync;

    // Single-bank palette storage, written only by the config port.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int unsigned e = 0; e < DEPTH; e++) begin
                r_palette[e] <= '0;
            end
        end else if (i_cfg_we) begin
            r_palette[i_cfg_addr] <= i_cfg_data;
        end
    end
`endif

    // Round-robin search starting at r_rr_ptr. No grant is made during reset or a blocking write.
    always_comb begin
        w_grant_found = 1'b0;
        w_grant_id    = '0;
        o_req_ready   = '0;
        if (!i_rst && !w_cfg_block) begin
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                if (!w_grant_found &&
                    i_req_valid[ID_W'((int'(r_rr_ptr) + int'(k)) % int'(NUM_REQ))]) begin
                    w_grant_found = 1'b1;
                    w_grant_id    = ID_W'((int'(r_rr_ptr) + int'(k)) % int'(NUM_REQ));
                end
            end
            if (w_grant_found) begin
                o_req_ready[w_grant_id] = 1'b1;
            end
        end
    end

    // Pick out the colour index of the granted requester.
    always_comb begin
        w_sel_index = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (w_grant_id == ID_W'(i)) begin
                w_sel_index = i_req_index[i*IDX_W +: IDX_W];
            end
        end
    end

    // After a grant, the pointer moves one place past the winner. Otherwise it holds.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rr_ptr <= '0;
        end else if (w_grant_found) begin
            r_rr_ptr <= (w_grant_id == ID_W'(NUM_REQ - 1)) ? '0 : w_grant_id + 1'b1;
        end
    end

    // One-cycle lookup response. The data fields hold their values while no lookup is granted.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rsp_valid       <= 1'b0;
            r_rsp_id          <= '0;
            r_rsp_rgb         <= '0;
            r_rsp_transparent <= 1'b0;
        end else begin
            r_rsp_valid <= w_grant_found;
            if (w_grant_found) begin
                r_rsp_id          <= w_grant_id;
                r_rsp_rgb         <= w_lookup_rgb;
                r_rsp_transparent <= (w_sel_index == '0);
            end
        end
    end

    assign o_rsp_valid       = r_rsp_valid;
    assign o_rsp_id          = r_rsp_id;
    assign o_rsp_rgb         = r_rsp_rgb;
    assign o_rsp_transparent = r_rsp_transparent;

endmodule

// File: tb/tb_palette_lookup_arbiter.sv
// Directed testbench for palette_lookup_arbiter (NUM_REQ=4, IDX_W=4).
// When PALETTE_DOUBLE_BUFFER_EN is defined, only the double-buffer sequence runs.
module tb_palette_lookup_arbiter;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned IDX_W   = 4;

    logic                       i_clk;
    logic                       i_rst;
    logic [NUM_REQ-1:0]         i_req_valid;
    logic [NUM_REQ*IDX_W-1:0]   i_req_index;
    logic [NUM_REQ-1:0]         o_req_ready;
    logic                       o_rsp_valid;
    logic [$clog2(NUM_REQ)-1:0] o_rsp_id;
    logic [11:0]                o_rsp_rgb;
    logic                       o_rsp_transparent;
    logic                       i_cfg_we;
    logic [IDX_W-1:0]           i_cfg_addr;
    logic [11:0]                i_cfg_data;
    logic                       i_frame_sync;

    int n_tests = 0;
    int n_fail  = 0;

    palette_lookup_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) dut (
        .i_clk            (i_clk),
        .i_rst            (i_rst),
        .i_req_valid      (i_req_valid),
        .i_req_index      (i_req_index),
        .o_req_ready      (o_req_ready),
        .o_rsp_valid      (o_rsp_valid),
        .o_rsp_id         (o_rsp_id),
        .o_rsp_rgb        (o_rsp_rgb),
        .o_rsp_transparent(o_rsp_transparent),
        .i_cfg_we         (i_cfg_we),
        .i_cfg_addr       (i_cfg_addr),
        .i_cfg_data       (i_cfg_data),
        .i_frame_sync     (i_frame_sync)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic set_idx(input int unsigned r, input logic [IDX_W-1:0] v);
        i_req_index[r*IDX_W +: IDX_W] = v;
    endtask

    task automatic chk_rsp(input string tag, input logic v, input logic [1:0] id,
                           input logic [11:0] rgb, input logic tr);
        chk({tag, "_valid"}, 32'(o_rsp_valid), 32'(v));
        chk({tag, "_id"},    32'(o_rsp_id),    32'(id));
        chk({tag, "_rgb"},   32'(o_rsp_rgb),   32'(rgb));
        chk({tag, "_tr"},    32'(o_rsp_transparent), 32'(tr));
    endtask

    initial begin
        i_rst        = 1'b1;
        i_req_valid  = 4'b1111;
        i_req_index  = '0;
        i_cfg_we     = 1'b0;
        i_cfg_addr   = '0;
        i_cfg_data   = '0;
        i_frame_sync = 1'b0;
        #1;
        chk("rst_ready", 32'(o_req_ready), 32'h0);
        chk_rsp("rst", 1'b0, 2'd0, 12'h000, 1'b0);
        tick();
        tick();
        i_req_valid = '0;
        i_rst       = 1'b0;
        #1;

`ifdef PALETTE_DOUBLE_BUFFER_EN
        // Write bank1[3] while looking up index 3 in the same cycle. The lookup reads bank0.
        i_cfg_we = 1'b1; i_cfg_addr = 4'd3; i_cfg_data = 12'h595;
        i_req_valid = 4'b0001; set_idx(0, 4'd3);
        #1;
        chk("db_wr_ready", 32'(o_req_ready), 32'h1);
        tick();
        i_cfg_we = 1'b0; i_req_valid = '0;
        chk_rsp("db_old", 1'b1, 2'd0, 12'h000, 1'b0);
        // Swap banks.
        i_frame_sync = 1'b1;
        tick();
        i_frame_sync = 1'b0;
        chk("db_idle", 32'(o_rsp_valid), 32'h0);
        i_req_valid = 4'b0001;
        tick();
        chk_rsp("db_new", 1'b1, 2'd0, 12'h595, 1'b0);
        // Write and swap at the same edge. This lookup still reads the pre-toggle bank.
        i_cfg_we = 1'b1; i_cfg_addr = 4'd3; i_cfg_data = 12'h0C3; i_frame_sync = 1'b1;
        tick();
        i_cfg_we = 1'b0; i_frame_sync = 1'b0;
        chk_rsp("db_sync_lu", 1'b1, 2'd0, 12'h595, 1'b0);
        tick();
        chk_rsp("db_after_sync", 1'b1, 2'd0, 12'h0C3, 1'b0);
        i_req_valid = '0;
        tick();
        chk("db_end", 32'(o_rsp_valid), 32'h0);
`else
        // A config write blocks requester 0.
        i_cfg_we = 1'b1; i_cfg_addr = 4'd1; i_cfg_data = 12'h7BD;
        i_req_valid = 4'b0001; set_idx(0, 4'd1);
        #1;
        chk("cfg1_ready", 32'(o_req_ready), 32'h0);
        tick();
        chk("cfg1_rsp", 32'(o_rsp_valid), 32'h0);
        i_req_valid = '0; i_cfg_addr = 4'd15; i_cfg_data = 12'hEEF;
        tick();
        i_cfg_we = 1'b0;
        // Requester 0 looks up index 1.
        i_req_valid = 4'b0001;
        #1;
        chk("lu1_ready", 32'(o_req_ready), 32'h1);
        tick();
        chk_rsp("lu1", 1'b1, 2'd0, 12'h7BD, 1'b0);
        // Index 0 is transparent and reads the reset value. rr_ptr=1 wraps around to 0.
        set_idx(0, 4'd0);
        #1;
        chk("tr_ready", 32'(o_req_ready), 32'h1);
        tick();
        chk_rsp("tr", 1'b1, 2'd0, 12'h000, 1'b1);
        // Idle cycle: valid drops and the data fields hold.
        i_req_valid = '0;
        tick();
        chk_rsp("idle", 1'b0, 2'd0, 12'h000, 1'b1);
        // A write blocks requester 2 for one cycle. The grant follows with the new value.
        i_cfg_we = 1'b1; i_cfg_addr = 4'd1; i_cfg_data = 12'hA30;
        i_req_valid = 4'b0100; set_idx(2, 4'd1);
        #1;
        chk("blk_ready", 32'(o_req_ready), 32'h0);
        tick();
        chk("blk_rsp", 32'(o_rsp_valid), 32'h0);
        i_cfg_we = 1'b0;
        #1;
        chk("blk_after_ready", 32'(o_req_ready), 32'h4);
        tick();
        chk_rsp("blk_after", 1'b1, 2'd2, 12'hA30, 1'b0);
        // rr_ptr is now 3, so requester 3 wins among all four.
        for (int r = 0; r < 4; r++) set_idx(r, 4'd15);
        i_req_valid = 4'b1111;
        #1;
        chk("ptr_ready", 32'(o_req_ready), 32'h8);
        tick();
        chk_rsp("ptr", 1'b1, 2'd3, 12'hEEF, 1'b0);
        // Requester 0 gets the next grant. Reset is asserted between edges, mid-stream.
        tick();
        chk_rsp("pre_rst", 1'b1, 2'd0, 12'hEEF, 1'b0);
        #2;
        i_rst = 1'b1;
        #1;
        chk("arst_ready", 32'(o_req_ready), 32'h0);
        chk_rsp("arst", 1'b0, 2'd0, 12'h000, 1'b0);
        tick();
        chk("arst_hold", 32'(o_rsp_valid), 32'h0);
        #2;
        i_rst = 1'b0;
        #1;
        // Grants run 0,1,2,3,0,1,2,3 from reset. Index 15 was cleared by reset.
        // A frame_sync pulse is applied and has no effect.
        for (int k = 0; k < 8; k++) begin
            i_frame_sync = (k == 2);
            #1;
            chk("rr_ready", 32'(o_req_ready), 32'(4'b0001 << (k % 4)));
            tick();
            chk_rsp("rr", 1'b1, 2'(k % 4), 12'h000, 1'b0);
        end
        i_frame_sync = 1'b0;
        i_req_valid = '0;
        tick();
        chk("end_idle", 32'(o_rsp_valid), 32'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/palette_lookup_arbiter.md
Name: palette_lookup_arbiter

Overview:
- Shared 16-entry, 12-bit RGB palette store for all sprite renderers feeding the VGA colour mux.
- Several sprite pipelines each present a 4-bit colour index and receive RGB one cycle later; one lookup is served per cycle under round-robin arbitration.
- A configuration port, driven by the game logic or CPU, loads palette entries at run time.
- Replaces the per-sprite constant palette ROMs with one writable, shared resource.

Parameters:
- NUM_REQ, 4, number of requesting sprite pipelines (2..8).
- IDX_W, 4, colour-index width; palette depth = 2**IDX_W.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester lookup request.
- req_index  in  NUM_REQ*IDX_W  packed indices; requester i uses bits [i*IDX_W +: IDX_W].
- req_ready  out  NUM_REQ  one-hot grant, combinational, same cycle as the request.
- rsp_valid  out  1  lookup result valid.
- rsp_id  out  $clog2(NUM_REQ)  requester the result belongs to.
- rsp_rgb  out  12  {red[3:0], green[3:0], blue[3:0]}.
- rsp_transparent  out  1  high when the looked-up index was 0.
- cfg_we  in  1  palette write strobe.
- cfg_addr  in  IDX_W  palette entry to write.
- cfg_data  in  12  RGB to write.
- frame_sync  in  1  single-cycle start-of-vblank pulse; used only with the optional feature.

Behaviour:
- Reset (async, any time, including mid-lookup):
  - All palette entries clear to 12'h000.
  - rr_ptr clears to 0.
  - rsp_valid, rsp_id, rsp_rgb and rsp_transparent clear to 0.
  - Active bank clears to 0.
  - req_ready is all-zero while Reset is high.
  - An in-flight lookup is discarded; no rsp_valid pulse follows after reset is released.
- Arbitration:
  - Search order is rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - The first requester with req_valid set gets req_ready[i]=1; at most one bit is set.
  - The transfer completes when req_valid[i] and req_ready[i] are both high at the rising edge.
  - After a grant to i, rr_ptr <= (i+1) mod NUM_REQ. With no grant, rr_ptr holds.
- Latency: exactly 1 cycle. The edge that accepts requester i's transfer registers:
  - rsp_valid=1, rsp_id=i.
  - rsp_rgb = palette[index].
  - rsp_transparent = (index==0).
  - In any cycle without a grant, rsp_valid=0 on the next cycle; rsp_rgb, rsp_id and rsp_transparent hold their last values.
- Throughput: one lookup per cycle, back-to-back, with no bubbles.
- Config priority: while cfg_we=1, req_ready is all-zero, no grant is made and rr_ptr holds.
  - The write lands at the edge.
  - A lookup granted in the following cycle returns the new value.
- Write/read ordering:
  - The palette is written only by cfg_we.
  - Lookups read the pre-edge contents.
  - Because writes block grants, no same-edge read/write conflict exists.
- Requester behaviour:
  - req_valid may drop without a grant; no state is kept for that requester.
  - A held request is guaranteed a grant within NUM_REQ arbitration cycles, excluding cycles blocked by cfg_we.
- frame_sync is ignored when the optional feature is compiled out.

Optional Feature:
- Macro: PALETTE_DOUBLE_BUFFER_EN.
- Defined:
  - Two banks of 16 entries.
  - Lookups read the active bank; cfg writes target the inactive bank and do not block grants.
  - frame_sync=1 toggles the active bank at that edge.
  - If cfg_we and frame_sync coincide, the write goes to the pre-toggle inactive bank, which becomes active after the edge.
  - A lookup granted in a frame_sync cycle reads the pre-toggle active bank.
- Undefined: single bank, behaviour exactly as above; frame_sync is unused.

Test Plan:
- Reset then config: write addr 1=12'h7BD, addr 15=12'hEEF. Requester 0 looks up index 1 -> next cycle rsp_valid=1, rsp_id=0, rsp_rgb=12'h7BD, rsp_transparent=0.
- Transparency: index 0 after reset -> rsp_rgb=12'h000, rsp_transparent=1.
- Round robin: all four requesters hold valid for 8 cycles from reset -> grants 0,1,2,3,0,1,2,3. rsp_id follows one cycle later with rsp_valid continuously high.
- Config blocking: cfg_we=1 (addr 1, 12'hA30) while requester 2 is valid -> req_ready=0 that cycle. Next cycle requester 2 is granted and gets 12'hA30; rr_ptr is unchanged by the blocked cycle.
- Async reset mid-stream: assert Reset between edges during continuous requests -> rsp_valid=0 and req_ready=0 immediately. After release, the first grant goes to requester 0, and a lookup of index 15 returns 12'h000.
- (PALETTE_DOUBLE_BUFFER_EN) Write bank1 addr 3=12'h595 with a lookup of index 3 in the same cycle -> returns 12'h000. Pulse frame_sync -> the next lookup of 3 returns 12'h595. Write and frame_sync in the same cycle -> the written value is visible on the following lookup.
